// File: rtl/audio_sel_pkg.sv
// Shared types and constants for the click-free audio source select sequencer.
package audio_sel_pkg;

  // Sequencer phases: wait for a sample boundary, mute, flip, settle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    MUTE   = 3'd2,
    SWITCH = 3'd3,
    SETTLE = 3'd4
  } state_e;

  // Avalon register indices.
  localparam logic [1:0] REG_SEL    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Bit positions inside the status register.
  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_PENDING_BIT = 1;
  localparam int unsigned STAT_DONE_BIT    = 2;

  localparam int unsigned DATA_W = 32;

endpackage : audio_sel_pkg

// File: rtl/audio_sel_tick_counter.sv
// Sample-tick counter shared by the mute and settle phases.
// last_c_o flags the tick that brings the count up to limit_i.
module audio_sel_tick_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             last_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_inc_c;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_c_o = tick_i & ~clr_i & (cnt_inc_c == limit_i);

endmodule : audio_sel_tick_counter

// File: rtl/audio_sel_sequencer.sv
// Avalon-MM slave owning the audio source select. A CPU write requests a new
// source; the flip happens only inside a sample-aligned mute window.
module audio_sel_sequencer
  import audio_sel_pkg::*;
#(
  parameter int unsigned MUTE_SAMPLES   = 4,
  parameter int unsigned SETTLE_SAMPLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  input  logic                sample_tick,
  output logic                out_port,
  output logic                mute,
  output logic                irq
);

  localparam logic [CNT_W-1:0] MUTE_LIM   = CNT_W'(MUTE_SAMPLES);
  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_SAMPLES);

  state_e state_q, state_d;
  logic   out_port_q, out_port_d;
  logic   pending_sel_q, pending_sel_d;
  logic   pending_q, pending_d;
  logic   target_sel_q, target_sel_d;
  logic   mute_q, mute_d;
  logic   done_q, done_d;
  logic   irq_en_q, irq_en_d;
  logic   irq_q, irq_d;

  logic   wr_c, sel_wr_c, stat_wr_c, ctrl_wr_c;
  logic   busy_c;
  logic   cnt_clr_c, cnt_tick_c, cnt_last_c;
  logic [CNT_W-1:0] cnt_limit_c;
  logic   wdata_unused_c;

  assign wr_c      = chipselect & ~write_n;
  assign sel_wr_c  = wr_c & (address == REG_SEL);
  assign stat_wr_c = wr_c & (address == REG_STATUS);
  assign ctrl_wr_c = wr_c & (address == REG_CTRL);
  assign busy_c    = (state_q != IDLE);

  // Only bit 0 of any register is writable.
  assign wdata_unused_c = ^writedata[DATA_W-1:1];

  assign cnt_limit_c = (state_q == SETTLE) ? SETTLE_LIM : MUTE_LIM;

  audio_sel_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (cnt_clr_c),
    .tick_i   (cnt_tick_c),
    .limit_i  (cnt_limit_c),
    .last_c_o (cnt_last_c)
  );

  // Next-state, register-write and output decode.
  always_comb begin
    state_d       = state_q;
    out_port_d    = out_port_q;
    pending_sel_d = pending_sel_q;
    pending_d     = pending_q;
    target_sel_d  = target_sel_q;
    mute_d        = mute_q;
    done_d        = done_q;
    irq_en_d      = irq_en_q;
    cnt_clr_c     = 1'b0;
    cnt_tick_c    = 1'b0;

    // Host clears come first so a same-cycle completion still sets done.
    if (stat_wr_c) begin
      done_d = 1'b0;
    end
    if (ctrl_wr_c) begin
      irq_en_d = writedata[0];
    end

    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          if (pending_sel_q != out_port_q) begin
            target_sel_d = pending_sel_q;
            state_d      = ALIGN;
          end
        end
      end
      ALIGN: begin
        // Mute onset is quantised to a sample boundary.
        if (sample_tick) begin
          mute_d    = 1'b1;
          cnt_clr_c = 1'b1;
          state_d   = MUTE;
        end
      end
      MUTE: begin
        cnt_tick_c = sample_tick;
        if (cnt_last_c) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        out_port_d = target_sel_q;
        cnt_clr_c  = 1'b1;
        state_d    = SETTLE;
      end
      SETTLE: begin
        cnt_tick_c = sample_tick;
        if (cnt_last_c) begin
          mute_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A select write while a sequence is committed or running always queues;
    // while quiet, only a real change queues. Set wins over the IDLE clear.
    if (sel_wr_c && ((writedata[0] != out_port_q) || busy_c || pending_q)) begin
      pending_sel_d = writedata[0];
      pending_d     = 1'b1;
    end
  end

  assign irq_d = done_d & irq_en_d;

  // State and register file.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      out_port_q    <= 1'b0;
      pending_sel_q <= 1'b0;
      pending_q     <= 1'b0;
      target_sel_q  <= 1'b0;
      mute_q        <= 1'b0;
      done_q        <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_port_q    <= out_port_d;
      pending_sel_q <= pending_sel_d;
      pending_q     <= pending_d;
      target_sel_q  <= target_sel_d;
      mute_q        <= mute_d;
      done_q        <= done_d;
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
    end
  end

  // Combinational read mux, zero-extended.
  always_comb begin
    readdata = '0;
    unique case (address)
      REG_SEL: begin
        readdata[0] = out_port_q;
      end
      REG_STATUS: begin
        readdata[STAT_BUSY_BIT]    = busy_c;
        readdata[STAT_PENDING_BIT] = pending_q;
        readdata[STAT_DONE_BIT]    = done_q;
      end
      REG_CTRL: begin
        readdata[0] = irq_en_q;
      end
      default: begin
        readdata = '0;
      end
    endcase
  end

  assign out_port = out_port_q;
  assign mute     = mute_q;
  assign irq      = irq_q;

endmodule : audio_sel_sequencer

// File: tb/tb_audio_sel_sequencer.sv
// Bench for audio_sel_sequencer: event times (mute rise, select flip, mute
// fall) are predicted from the recorded sample-tick edges.
module tb_audio_sel_sequencer;

  localparam int MUTE_N   = 4;
  localparam int SETTLE_N = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        sample_tick = 1'b0;
  logic        out_port;
  logic        mute;
  logic        irq;

  always #5 clk = ~clk;

  audio_sel_sequencer #(
    .MUTE_SAMPLES   (MUTE_N),
    .SETTLE_SAMPLES (SETTLE_N),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .sample_tick (sample_tick),
    .out_port    (out_port),
    .mute        (mute),
    .irq         (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int period   = 16;
  int tick_q[$];
  int rise_q[$];
  int fall_q[$];
  int flip_q[$];
  logic prev_mute = 1'b0;
  logic prev_out  = 1'b0;

  // One clock edge with the given inputs; records ticks and output edges.
  task automatic step(input bit tk, input bit wr, input logic [1:0] a, input logic [31:0] d);
    sample_tick = tk;
    chipselect  = wr;
    write_n     = ~wr;
    address     = a;
    writedata   = d;
    @(posedge clk);
    cyc++;
    if (tk) tick_q.push_back(cyc);
    #1;
    if (mute !== prev_mute) begin
      if (mute === 1'b1) rise_q.push_back(cyc);
      else fall_q.push_back(cyc);
    end
    if (out_port !== prev_out) flip_q.push_back(cyc);
    prev_mute   = mute;
    prev_out    = out_port;
    sample_tick = 1'b0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
  endtask

  function automatic bit gen_tick();
    if (period == 0) return ($urandom_range(0, 3) == 0);
    return ((cyc + 1) % period) == 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) step(gen_tick(), 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    v          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic clear_obs();
    rise_q.delete();
    fall_q.delete();
    flip_q.delete();
  endtask

  // Edge of the n-th recorded tick strictly after edge e, or -1.
  function automatic int nth_tick_after(input int e, input int n);
    int c = 0;
    foreach (tick_q[i]) begin
      if (tick_q[i] > e) begin
        c++;
        if (c == n) return tick_q[i];
      end
    end
    return -1;
  endfunction

  // Sequence entering the align phase at edge a: mute rise, flip, mute fall.
  task automatic predict(input int a, output int r, output int f, output int s);
    int m;
    r = nth_tick_after(a, 1);
    m = nth_tick_after(r, MUTE_N);
    f = (m < 0) ? -1 : m + 1;
    s = nth_tick_after(f, SETTLE_N);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b0, 2'd0, 32'd0);
    reset_n = 1'b1;
    clear_obs();
  endtask

  // Polls status until neither busy nor pending, bounded.
  task automatic wait_idle(output bit ok);
    logic [31:0] v;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rd(2'd1, v);
      if (v[1:0] == 2'b00) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
  endtask

  task automatic tick_gap(input bit wr, input logic [1:0] a);
    repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, wr, a, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_read addr%0d: got %h expected 0", a, v);
      end
    end
    n_checks++;
    if (out_port !== 1'b0 || mute !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: out=%b mute=%b irq=%b expected 000", out_port, mute, irq);
    end
  endtask

  task automatic test_basic_switch();
    logic [31:0] v;
    bit ok;
    int w, r, f, s;
    do_reset();
    period = 16;
    step(gen_tick(), 1'b1, 2'd0, 32'd1);
    w = cyc;
    rd(2'd1, v);
    n_checks++;
    if (v[2:0] !== 3'b010) begin
      n_fail++;
      $display("FAIL basic_pending: status=%h expected 2", v);
    end
    idle(1);
    rd(2'd1, v);
    n_checks++;
    if (v[1:0] !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_busy: status=%h expected busy only", v);
    end
    wait_idle(ok);
    idle(4);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_timeout: sequence never finished");
    end
    predict(w + 1, r, f, s);
    n_checks++;
    if (rise_q.size() != 1 || rise_q[0] != r) begin
      n_fail++;
      $display("FAIL basic_mute_rise: n=%0d first=%0d expected edge %0d", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, r);
    end
    n_checks++;
    if (flip_q.size() != 1 || flip_q[0] != f) begin
      n_fail++;
      $display("FAIL basic_flip: n=%0d first=%0d expected edge %0d", flip_q.size(), (flip_q.size() > 0) ? flip_q[0] : -1, f);
    end
    n_checks++;
    if (fall_q.size() != 1 || fall_q[0] != s) begin
      n_fail++;
      $display("FAIL basic_mute_fall: n=%0d first=%0d expected edge %0d", fall_q.size(), (fall_q.size() > 0) ? fall_q[0] : -1, s);
    end
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'd4 || out_port !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_final: status=%h out=%b expected 4 and 1", v, out_port);
    end
  endtask

  task automatic test_same_value();
    logic [31:0] v;
    do_reset();
    period = 16;
    step(gen_tick(), 1'b1, 2'd0, 32'd0);
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL same_status_now: status=%h expected 0", v);
    end
    idle(60);
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'd0 || rise_q.size() != 0 || out_port !== 1'b0) begin
      n_fail++;
      $display("FAIL same_no_effect: status=%h rises=%0d out=%b expected 0 0 0", v, rise_q.size(), out_port);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int w, r1, f1, s1, r2, f2, s2, guard;
    do_reset();
    period = 16;
    step(gen_tick(), 1'b1, 2'd0, 32'd1);
    w = cyc;
    guard = 0;
    while (mute !== 1'b1 && guard < 100) begin
      idle(1);
      guard++;
    end
    idle(3);
    step(gen_tick(), 1'b1, 2'd0, 32'd0);
    n_checks++;
    if (mute !== 1'b1 || flip_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_in_mute: mute=%b flips=%0d expected 1 0", mute, flip_q.size());
    end
    wait_idle(ok);
    idle(4);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_timeout: sequences never finished");
    end
    predict(w + 1, r1, f1, s1);
    predict(s1 + 1, r2, f2, s2);
    n_checks++;
    if (rise_q.size() != 2 || rise_q[0] != r1 || rise_q[1] != r2) begin
      n_fail++;
      $display("FAIL b2b_rises: n=%0d expected 2 at %0d,%0d", rise_q.size(), r1, r2);
    end
    n_checks++;
    if (flip_q.size() != 2 || flip_q[0] != f1 || flip_q[1] != f2) begin
      n_fail++;
      $display("FAIL b2b_flips: n=%0d expected 2 at %0d,%0d", flip_q.size(), f1, f2);
    end
    n_checks++;
    if (fall_q.size() != 2 || fall_q[0] != s1 || fall_q[1] != s2) begin
      n_fail++;
      $display("FAIL b2b_falls: n=%0d expected 2 at %0d,%0d", fall_q.size(), s1, s2);
    end
    n_checks++;
    if (out_port !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_final_out: got %b expected 0", out_port);
    end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    do_reset();
    step(1'b0, 1'b1, 2'd2, 32'd1);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'd1) begin
      n_fail++;
      $display("FAIL irq_ctrl_read: got %h expected 1", v);
    end
    step(1'b0, 1'b1, 2'd0, 32'd1);
    step(1'b0, 1'b0, 2'd0, 32'd0);
    repeat (1 + MUTE_N) tick_gap(1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0, 32'd0);
    repeat (SETTLE_N - 1) tick_gap(1'b0, 2'd0);
    n_checks++;
    if (irq !== 1'b0 || mute !== 1'b1 || out_port !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_before_done: irq=%b mute=%b out=%b expected 0 1 1", irq, mute, out_port);
    end
    tick_gap(1'b0, 2'd0);
    n_checks++;
    if (irq !== 1'b1 || mute !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_on_done: irq=%b mute=%b expected 1 0", irq, mute);
    end
    step(1'b0, 1'b1, 2'd1, 32'd0);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
    step(1'b0, 1'b1, 2'd0, 32'd0);
    step(1'b0, 1'b0, 2'd0, 32'd0);
    repeat (1 + MUTE_N) tick_gap(1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0, 32'd0);
    repeat (SETTLE_N - 1) tick_gap(1'b0, 2'd0);
    tick_gap(1'b1, 2'd1);
    rd(2'd1, v);
    n_checks++;
    if (irq !== 1'b1 || v !== 32'd4 || out_port !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_set_wins: irq=%b status=%h out=%b expected 1 4 0", irq, v, out_port);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    step(1'b0, 1'b1, 2'd0, 32'd1);
    step(1'b0, 1'b0, 2'd0, 32'd0);
    repeat (1 + MUTE_N) tick_gap(1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0, 32'd0);
    tick_gap(1'b0, 2'd0);
    n_checks++;
    if (out_port !== 1'b1 || mute !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_settle: out=%b mute=%b expected 1 1", out_port, mute);
    end
    reset_n = 1'b0;
    step(1'b1, 1'b0, 2'd0, 32'd0);
    reset_n = 1'b1;
    clear_obs();
    rd(2'd1, v);
    n_checks++;
    if (out_port !== 1'b0 || mute !== 1'b0 || irq !== 1'b0 || v !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_cleared: out=%b mute=%b irq=%b status=%h expected all 0", out_port, mute, irq, v);
    end
    repeat (12) tick_gap(1'b0, 2'd0);
    rd(2'd1, v);
    n_checks++;
    if (rise_q.size() != 0 || flip_q.size() != 0 || v !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_quiet: rises=%0d flips=%0d status=%h expected 0 0 0", rise_q.size(), flip_q.size(), v);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic exp_sel;
    logic vsel;
    int w, r, f, s;
    do_reset();
    period  = 0;
    exp_sel = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clear_obs();
      idle($urandom_range(0, 7));
      vsel = 1'($urandom_range(0, 1));
      step(gen_tick(), 1'b1, 2'd0, {31'd0, vsel});
      w = cyc;
      wait_idle(ok);
      idle(3);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_timeout: iter %0d", k);
      end
      if (vsel != exp_sel) begin
        predict(w + 1, r, f, s);
        n_checks++;
        if (rise_q.size() != 1 || rise_q[0] != r || flip_q.size() != 1 || flip_q[0] != f ||
            fall_q.size() != 1 || fall_q[0] != s) begin
          n_fail++;
          $display("FAIL rand_seq iter %0d: rises=%0d flips=%0d falls=%0d expected edges %0d/%0d/%0d",
                   k, rise_q.size(), flip_q.size(), fall_q.size(), r, f, s);
        end
        exp_sel = vsel;
      end else begin
        n_checks++;
        if (rise_q.size() != 0 || flip_q.size() != 0) begin
          n_fail++;
          $display("FAIL rand_noop iter %0d: rises=%0d flips=%0d expected 0 0", k, rise_q.size(), flip_q.size());
        end
      end
      n_checks++;
      if (out_port !== exp_sel) begin
        n_fail++;
        $display("FAIL rand_out iter %0d: got %b expected %b", k, out_port, exp_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_switch();
    test_same_value();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_audio_sel_sequencer
